// File: rtl/prog_ctr_stack.sv
// -----------------------------------------------------------------------------
// prog_ctr_stack
//
// Program counter for the CPU fetch stage. It supports absolute and relative
// branches, unconditional jumps and stall. It also has a small hardware
// return-address stack for call and return.
//
// The priority applied at each rising edge (first match wins) is:
//   hold (Start=0) > stall > return > call > taken branch > increment.
// A call pushes PC+1 and jumps to Target. A return pops the top entry into PC.
// A call while the stack is full, or a return while it is empty, falls back
// to a plain increment and sets a sticky error flag. Only reset clears it.
//
// Ports:
//   Clk            clock, all state changes on the rising edge
//   Reset          synchronous, active-low reset
//   Start          1 = run, 0 = hold all state
//   Stall          1 = hold PC, stack and flags this cycle
//   BranchEn       branch instruction this cycle
//   Uncond         with BranchEn: take the branch regardless of ZeroFlag
//   ZeroFlag       ALU zero flag, qualifies a conditional branch
//   BranchRel      0 = absolute (Target), 1 = relative (PC + Offset)
//   Target         absolute branch / call destination
//   Offset         signed relative branch offset
//   CallEn         push PC+1 and jump to Target
//   RetEn          pop the stack into PC
//   ProgCtr        current program counter (registered)
//   StackCount     occupied return-stack entries
//   StackOverflow  sticky: call attempted while the stack was full
//   StackUnderflow sticky: return attempted while the stack was empty
// -----------------------------------------------------------------------------
module prog_ctr_stack #(
    parameter int PC_W        = 10,
    parameter int OFF_W       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               Start,
    input  logic                               Stall,
    input  logic                               BranchEn,
    input  logic                               Uncond,
    input  logic                               ZeroFlag,
    input  logic                               BranchRel,
    input  logic [PC_W-1:0]                    Target,
    input  logic [OFF_W-1:0]                   Offset,
    input  logic                               CallEn,
    input  logic                               RetEn,
    output logic [PC_W-1:0]                    ProgCtr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   StackCount,
    output logic                               StackOverflow,
    output logic                               StackUnderflow
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

    logic [PC_W-1:0]  pc_reg, pc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             push;

    // Return-address storage. Its contents are don't-care after reset
    // because StackCount alone decides which entries are valid.
    logic [PC_W-1:0]  stack_mem [STACK_DEPTH];

    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  stack_top;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;

    assign pc_inc  = pc_reg + PC_W'(1);
    // Sign-extend the offset to PC width. The add below then wraps
    // naturally in PC_W bits, in both directions.
    assign off_ext = PC_W'($signed(Offset));

    // The next free slot is the current count. The top entry sits one
    // below it. Both indices are only used when in range: push needs a
    // non-full stack, and pop needs a non-empty stack.
    assign wr_idx    = PTR_W'(cnt_reg);
    assign rd_idx    = PTR_W'(cnt_reg - CNT_W'(1));
    assign stack_top = stack_mem[rd_idx];

    always_comb begin
        pc_next  = pc_reg;
        cnt_next = cnt_reg;
        ovf_next = ovf_reg;
        unf_next = unf_reg;
        push     = 1'b0;

        if (Start && !Stall) begin
            if (RetEn) begin
                if (cnt_reg != '0) begin
                    pc_next  = stack_top;
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    pc_next  = pc_inc;
                    unf_next = 1'b1;
                end
            end else if (CallEn) begin
                if (cnt_reg < DEPTH_C) begin
                    push     = 1'b1;
                    pc_next  = Target;
                    cnt_next = cnt_reg + CNT_W'(1);
                end else begin
                    pc_next  = pc_inc;
                    ovf_next = 1'b1;
                end
            end else if (BranchEn && (Uncond || ZeroFlag)) begin
                pc_next = BranchRel ? (pc_reg + off_ext) : Target;
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_reg  <= PC_W'(RESET_PC);
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            pc_reg  <= pc_next;
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
        end
    end

    // A stray write during reset is harmless, because reset clears the
    // count and so no entry stays valid.
    always_ff @(posedge Clk) begin
        if (push) begin
            stack_mem[wr_idx] <= pc_inc;
        end
    end

    assign ProgCtr        = pc_reg;
    assign StackCount     = cnt_reg;
    assign StackOverflow  = ovf_reg;
    assign StackUnderflow = unf_reg;

endmodule

// File: tb/tb_prog_ctr_stack.sv
// -----------------------------------------------------------------------------
// tb_prog_ctr_stack
//
// Bench for prog_ctr_stack with default parameters (PC_W=10, OFF_W=8,
// STACK_DEPTH=4, RESET_PC=0).
//
// The directed scenarios compare against literal expected values.
// The randomized scenario compares against a reference model. The model keeps
// the return stack as a queue and computes the PC with integer arithmetic
// modulo 1024.
// -----------------------------------------------------------------------------
module tb_prog_ctr_stack;

    logic       clk = 1'b0;
    logic       rst_n, start, stall, br_en, uncond, zero, br_rel, call_en, ret_en;
    logic [9:0] target;
    logic [7:0] offset;
    logic [9:0] prog_ctr;
    logic [2:0] stack_count;
    logic       stack_ovf, stack_unf;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int m_pc = 0;
    int m_stack[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    always #5 clk = ~clk;

    prog_ctr_stack dut (
        .Clk           (clk),
        .Reset         (rst_n),
        .Start         (start),
        .Stall         (stall),
        .BranchEn      (br_en),
        .Uncond        (uncond),
        .ZeroFlag      (zero),
        .BranchRel     (br_rel),
        .Target        (target),
        .Offset        (offset),
        .CallEn        (call_en),
        .RetEn         (ret_en),
        .ProgCtr       (prog_ctr),
        .StackCount    (stack_count),
        .StackOverflow (stack_ovf),
        .StackUnderflow(stack_unf)
    );

    function automatic logic [14:0] pack(int pc, int cnt, bit o, bit u);
        return {10'(pc), 3'(cnt), o, u};
    endfunction

    function automatic logic [14:0] observed();
        return {prog_ctr, stack_count, stack_ovf, stack_unf};
    endfunction

    // Model: one rising edge, following the priority rules directly.
    task automatic model_step();
        int off;
        off = int'($signed(offset));
        if (!rst_n) begin
            m_pc = 0;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (!start || stall) begin
            // hold
        end else if (ret_en) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_pc = (m_pc + 1) % 1024; m_unf = 1; end
        end else if (call_en) begin
            if (m_stack.size() < 4) begin
                m_stack.push_back((m_pc + 1) % 1024);
                m_pc = int'(target);
            end else begin
                m_pc = (m_pc + 1) % 1024;
                m_ovf = 1;
            end
        end else if (br_en && (uncond || zero)) begin
            if (br_rel) m_pc = (((m_pc + off) % 1024) + 1024) % 1024;
            else        m_pc = int'(target);
        end else begin
            m_pc = (m_pc + 1) % 1024;
        end
    endtask

    task automatic drive(bit r, bit s, bit st, bit b, bit u, bit z, bit rel,
                         int tgt, int off, bit c, bit rt);
        rst_n = r; start = s; stall = st; br_en = b; uncond = u; zero = z;
        br_rel = rel; target = 10'(tgt); offset = 8'(off); call_en = c; ret_en = rt;
    endtask

    // Inputs change on the falling edge. The DUT samples them on the rising
    // edge, and outputs are read back on the next falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Shorthands for common operations, all with Reset=1 and Start=1.
    task automatic op_inc();          drive(1,1,0,0,0,0,0,0,0,0,0); tick(); endtask
    task automatic op_jump(int t);    drive(1,1,0,1,1,0,0,t,0,0,0); tick(); endtask
    task automatic op_call(int t);    drive(1,1,0,0,0,0,0,t,0,1,0); tick(); endtask
    task automatic op_ret();          drive(1,1,0,0,0,0,0,0,0,0,1); tick(); endtask

    task automatic test_reset();
        logic [14:0] exp;
        drive(0,1,0,0,0,0,0,0,0,0,0); tick();
        exp = pack(0,0,0,0);
        n_vec++;
        $display("reset        obs=%h exp=%h", observed(), exp);
        if (observed() !== exp) begin n_err++; $display("FAIL reset: got %h want %h", observed(), exp); end
        for (int i = 0; i < 2; i++) begin
            drive(1,0,0,0,0,0,0,0,0,0,0); tick();
            n_vec++;
            $display("hold_start%0d  obs=%h exp=%h", i, observed(), exp);
            if (observed() !== exp) begin n_err++; $display("FAIL hold_start%0d: got %h want %h", i, observed(), exp); end
        end
    endtask

    task automatic test_count_branch();
        logic [14:0] exp;
        for (int i = 1; i <= 3; i++) begin
            op_inc();
            exp = pack(i,0,0,0);
            n_vec++;
            $display("count%0d       obs=%h exp=%h", i, observed(), exp);
            if (observed() !== exp) begin n_err++; $display("FAIL count%0d: got %h want %h", i, observed(), exp); end
        end
        drive(1,1,1,0,0,0,0,0,0,0,0); tick();
        exp = pack(3,0,0,0);
        n_vec++;
        $display("stall        obs=%h exp=%h", observed(), exp);
        if (observed() !== exp) begin n_err++; $display("FAIL stall: got %h want %h", observed(), exp); end
        drive(1,1,0,1,0,1,0,100,0,0,0); tick();
        exp = pack(100,0,0,0);
        n_vec++;
        $display("br_taken     obs=%h exp=%h", observed(), exp);
        if (observed() !== exp) begin n_err++; $display("FAIL br_taken: got %h want %h", observed(), exp); end
        drive(1,1,0,1,0,0,0,100,0,0,0); tick();
        exp = pack(101,0,0,0);
        n_vec++;
        $display("br_untaken   obs=%h exp=%h", observed(), exp);
        if (observed() !== exp) begin n_err++; $display("FAIL br_untaken: got %h want %h", observed(), exp); end
    endtask

    task automatic test_relative();
        logic [14:0] exp;
        op_jump(100);
        drive(1,1,0,1,1,0,1,0,8'hFC,0,0); tick();
        exp = pack(96,0,0,0);
        n_vec++;
        $display("rel_back     obs=%h exp=%h", observed(), exp);
        if (observed() !== exp) begin n_err++; $display("FAIL rel_back: got %h want %h", observed(), exp); end
        op_jump(1020);
        drive(1,1,0,1,1,0,1,0,10,0,0); tick();
        exp = pack(6,0,0,0);
        n_vec++;
        $display("rel_wrap     obs=%h exp=%h", observed(), exp);
        if (observed() !== exp) begin n_err++; $display("FAIL rel_wrap: got %h want %h", observed(), exp); end
        op_jump(1023);
        op_inc();
        exp = pack(0,0,0,0);
        n_vec++;
        $display("inc_wrap     obs=%h exp=%h", observed(), exp);
        if (observed() !== exp) begin n_err++; $display("FAIL inc_wrap: got %h want %h", observed(), exp); end
    endtask

    task automatic test_call_ret();
        logic [14:0] exp_tab [5];
        exp_tab[0] = pack(200,1,0,0);
        exp_tab[1] = pack(300,2,0,0);
        exp_tab[2] = pack(201,1,0,0);
        exp_tab[3] = pack(11,0,0,0);
        exp_tab[4] = pack(12,0,0,1);
        op_jump(10);
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      op_call(200);
            else if (i == 1) op_call(300);
            else             op_ret();
            n_vec++;
            $display("call_ret%0d    obs=%h exp=%h", i, observed(), exp_tab[i]);
            if (observed() !== exp_tab[i]) begin n_err++; $display("FAIL call_ret%0d: got %h want %h", i, observed(), exp_tab[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [14:0] exp;
        int ret_pc [4] = '{71, 61, 51, 1};
        drive(0,1,0,0,0,0,0,0,0,0,0); tick();
        for (int i = 0; i < 5; i++) op_call(50 + 10*i);
        exp = pack(81,4,1,0);
        n_vec++;
        $display("overflow     obs=%h exp=%h", observed(), exp);
        if (observed() !== exp) begin n_err++; $display("FAIL overflow: got %h want %h", observed(), exp); end
        for (int i = 0; i < 4; i++) begin
            op_ret();
            exp = pack(ret_pc[i], 3-i, 1, 0);
            n_vec++;
            $display("unwind%0d      obs=%h exp=%h", i, observed(), exp);
            if (observed() !== exp) begin n_err++; $display("FAIL unwind%0d: got %h want %h", i, observed(), exp); end
        end
    endtask

    task automatic test_priority_and_mid_reset();
        logic [14:0] exp;
        op_jump(41);
        op_call(5);
        drive(1,1,0,1,1,0,0,700,0,1,1); tick();
        exp = pack(42,0,1,0);
        n_vec++;
        $display("call_and_ret obs=%h exp=%h", observed(), exp);
        if (observed() !== exp) begin n_err++; $display("FAIL call_and_ret: got %h want %h", observed(), exp); end
        op_ret();
        op_call(100); op_call(200); op_call(300);
        exp = pack(300,3,1,1);
        n_vec++;
        $display("pre_reset    obs=%h exp=%h", observed(), exp);
        if (observed() !== exp) begin n_err++; $display("FAIL pre_reset: got %h want %h", observed(), exp); end
        drive(0,1,0,1,1,1,0,500,0,1,1); tick();
        exp = pack(0,0,0,0);
        n_vec++;
        $display("mid_reset    obs=%h exp=%h", observed(), exp);
        if (observed() !== exp) begin n_err++; $display("FAIL mid_reset: got %h want %h", observed(), exp); end
    endtask

    task automatic test_random();
        logic [14:0] exp;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(31,0) != 0, $urandom_range(7,0) != 0,
                  $urandom_range(7,0) == 0, $urandom_range(1,0) == 1,
                  $urandom_range(1,0) == 1, $urandom_range(1,0) == 1,
                  $urandom_range(1,0) == 1, int'($urandom_range(1023,0)),
                  int'($urandom_range(255,0)), $urandom_range(3,0) == 0,
                  $urandom_range(3,0) == 0);
            tick();
            exp = pack(m_pc, m_stack.size(), m_ovf, m_unf);
            n_vec++;
            $display("rand%0d obs=%h exp=%h", i, observed(), exp);
            if (observed() !== exp) begin n_err++; $display("FAIL rand%0d: got %h want %h", i, observed(), exp); end
        end
    endtask

    initial begin
        drive(0,0,0,0,0,0,0,0,0,0,0);
        @(negedge clk);
        test_reset();
        test_count_branch();
        test_relative();
        test_call_ret();
        test_overflow();
        test_priority_and_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_ctr_stack.md
Name: prog_ctr_stack

Overview:
Parametrised next-generation program counter for the CPU fetch stage. Adds relative branches, unconditional jumps, stall and a hardware return-address stack (call/return) to the basic start/branch-on-zero counter. Drives the instruction-memory address every cycle and reports stack status to the control unit.

Parameters:
PC_W, 10, program counter / target width in bits
OFF_W, 8, signed relative-branch offset width (OFF_W <= PC_W)
STACK_DEPTH, 4, return-address stack entries (>= 2)
RESET_PC, 0, PC value loaded on reset

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-low reset
Start  input  1  1 = run; 0 = PC holds
Stall  input  1  1 = hold PC and stack this cycle
BranchEn  input  1  branch instruction in current cycle
Uncond  input  1  with BranchEn: branch ignores ZeroFlag
ZeroFlag  input  1  ALU zero flag, qualifies conditional branch
BranchRel  input  1  0 = absolute (Target), 1 = relative (PC + Offset)
Target  input  PC_W  absolute branch / call destination
Offset  input  OFF_W  signed two's-complement relative offset
CallEn  input  1  push PC+1, jump to Target
RetEn  input  1  pop stack into PC
ProgCtr  output  PC_W  current program counter (registered)
StackCount  output  $clog2(STACK_DEPTH+1)  occupied stack entries
StackOverflow  output  1  sticky: call attempted while full
StackUnderflow  output  1  sticky: return attempted while empty

Behaviour:
- Reset (Reset==0 at rising edge): ProgCtr=RESET_PC, StackCount=0, StackOverflow=0, StackUnderflow=0; stack contents don't-care. Reset overrides all other inputs, including mid-call/return.
- All outputs registered; one-cycle latency from control inputs to ProgCtr.
- Per-edge priority (first match wins), when Reset==1:
  1. Start==0: hold everything.
  2. Stall==1: hold everything (flags retain).
  3. RetEn==1: if StackCount>0, PC <= top entry, StackCount-1. If empty, PC <= PC+1, StackUnderflow <= 1. CallEn/BranchEn ignored.
  4. CallEn==1: if StackCount<STACK_DEPTH, push PC+1 (mod 2^PC_W), PC <= Target, StackCount+1. If full, no push, PC <= PC+1, StackOverflow <= 1. BranchEn ignored.
  5. BranchEn==1 and (Uncond==1 or ZeroFlag==1): PC <= Target if BranchRel==0, else PC + sign_extend(Offset) mod 2^PC_W.
  6. Otherwise: PC <= PC+1 mod 2^PC_W (2^PC_W-1 wraps to 0).
- Untaken conditional branch (ZeroFlag==0, Uncond==0) increments as step 6.
- Stack is LIFO; pushed value is PC+1 from the call cycle, wrapped.
- Sticky flags clear only on reset; PC, stack and StackCount stay legal after errors.
- Relative arithmetic in PC_W bits, wrap both directions, no saturation.

Test Plan:
- Reset=0 one edge, then Reset=1, Start=0, two edges -> ProgCtr=0, StackCount=0, both flags 0 throughout.
- Start=1, three edges -> ProgCtr 1,2,3; Stall=1 one edge -> stays 3; BranchEn=1, ZeroFlag=1, BranchRel=0, Target=100 -> 100; same with ZeroFlag=0, Uncond=0 -> 101.
- PC=100, BranchEn=1, Uncond=1, BranchRel=1, Offset=-4 (8'hFC) -> 96; PC=1020, Offset=+10 -> 6 (wrap); PC=1023 plain increment -> 0.
- PC=10 CallEn Target=200 -> PC=200, StackCount=1; CallEn Target=300 -> 300, count 2; RetEn -> 201, count 1; RetEn -> 11, count 0; RetEn again -> 12, StackUnderflow=1, count 0.
- Five calls from PC=0 with Targets 50,60,70,80,90 -> 5th call: PC=81, StackCount=4, StackOverflow=1; four returns -> 71, 61, 51, 1.
- CallEn and RetEn together with stack holding 42 -> PC=42, no push; Reset=0 mid-sequence with count 3, flags set -> ProgCtr=0, count 0, flags 0 next edge.
